// File: rtl/hyperram_txn_seq.sv
// HyperRAM transaction sequencer: accepts one request, sends the three CA words,
// waits out initial latency, runs the write or read data phase, then holds and recovers CS#.
module hyperram_txn_seq #(
  parameter int LATENCY_CLKS = 6,
  parameter int LEN_W        = 8,
  parameter int CS_HOLD_CLKS = 1,
  parameter int RECOVER_CLKS = 2,
  parameter int RD_TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_reg,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [15:0]      wr_data,
  input  logic [1:0]       wr_mask,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      rd_word_in,
  input  logic             rd_word_in_vld,
  input  logic             rwds_in,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic [15:0]      ddr_dout,
  output logic             ddr_oe,
  output logic [1:0]       rwds_dout,
  output logic             rwds_oe,
  output logic             cs_n,
  output logic             ck_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W = LEN_W + 1;
  localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // may not depend on ready, and the sequencer never waits on valid once in DATA.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CA   = 3'd1,
    S_LAT  = 3'd2,
    S_DATA = 3'd3,
    S_HOLD = 3'd4,
    S_REC  = 3'd5
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic               err_q, err_d;
  logic               lat_dbl, lat_dbl_d;
  logic               wr_q, reg_q;
  logic [47:0]        ca_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   lat_last, data_last;
  logic               rd_capture;

  assign lat_last   = lat_dbl ? CNT_W'(2 * LATENCY_CLKS - 1) : CNT_W'(LATENCY_CLKS - 1);
  // Register writes carry exactly one word regardless of the requested length.
  assign data_last  = (wr_q && reg_q) ? '0 : len_q - CNT_W'(1);
  assign rd_capture = (state == S_DATA) && !wr_q && rd_word_in_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      timer    <= '0;
      err_q    <= 1'b0;
      lat_dbl  <= 1'b0;
      wr_q     <= 1'b0;
      reg_q    <= 1'b0;
      ca_q     <= '0;
      len_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      timer    <= timer_d;
      err_q    <= err_d;
      lat_dbl  <= lat_dbl_d;
      rd_valid <= rd_capture;
      if (rd_capture) rd_data <= rd_word_in;
      if (state == S_IDLE && req_valid) begin
        wr_q  <= req_write;
        reg_q <= req_reg;
        ca_q  <= {~req_write, req_reg, 1'b1, req_addr[31:3], 13'd0, req_addr[2:0]};
        len_q <= (req_len == '0) ? CNT_W'(1) : {1'b0, req_len};
      end
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    timer_d   = timer;
    err_d     = err_q;
    lat_dbl_d = lat_dbl;
    case (state)
      S_IDLE: if (req_valid) begin
        state_d = S_CA;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      S_CA: begin
        if (cnt == CNT_W'(1)) lat_dbl_d = rwds_in;
        if (cnt == CNT_W'(2)) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = (wr_q && reg_q) ? S_DATA : S_LAT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_LAT: begin
        if (cnt == lat_last) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (wr_q) begin
          if (!wr_valid) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_HOLD;
          end else if (cnt == data_last) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else if (rd_word_in_vld) begin
          timer_d = '0;
          if (cnt == data_last) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else if (timer == TMR_W'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == CNT_W'(CS_HOLD_CLKS - 1)) begin
          cnt_d   = '0;
          state_d = S_REC;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_REC: begin
        if (cnt == CNT_W'(RECOVER_CLKS - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ddr_dout  = '0;
    rwds_dout = '0;
    ddr_oe    = 1'b0;
    rwds_oe   = 1'b0;
    wr_ready  = 1'b0;
    if (state == S_CA) begin
      ddr_oe = 1'b1;
      case (cnt)
        CNT_W'(0): ddr_dout = ca_q[47:32];
        CNT_W'(1): ddr_dout = ca_q[31:16];
        default:   ddr_dout = ca_q[15:0];
      endcase
    end else if (state == S_DATA && wr_q) begin
      ddr_oe    = 1'b1;
      rwds_oe   = 1'b1;
      wr_ready  = 1'b1;
      ddr_dout  = wr_data;
      rwds_dout = wr_mask;
    end
  end

  // CS# and CK gating follow state directly, so ck_en can never be high with CS# high.
  assign req_ready = (state == S_IDLE);
  assign cs_n      = (state == S_IDLE) || (state == S_REC);
  assign ck_en     = (state == S_CA) || (state == S_LAT) || (state == S_DATA);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_REC) && (cnt == '0);
  assign err       = done && err_q;
  assign dbg_state = state;

endmodule
